frontend_redirect_arbiter: RTL and testbench

Arbitrates the two frontend redirect sources: the backend (mispredict/exception commit) and the predecode stage (direct-jump/no-branch errors). Registers the winning redirect, presents it to the FSQ with a valid/ready handshake, and pulses the frontend flush. It then holds fetch stalled for a programmable drain window so squashed fetch blocks cannot raise stale predecode redirects. Sits between the backend and predecode redirect outputs and the FSQ/BPU redirect input, and drives the frontend control redirect/stall bits.

---
 rtl/frontend_redirect_arbiter.sv | 100 ++++++++++
 tb/tb_frontend_redirect_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frontend_redirect_arbiter.sv
// Picks a backend or predecode redirect, registers it for the FSQ, flushes and then stalls fetch for a drain window.
// Request to redirect_valid is 1 cycle; the redirect is held until fsq_ready, and backend requests may replace it at any time.
module frontend_redirect_arbiter #(
  parameter int VADDR_W      = 39,
  parameter int FSQ_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 be_redirect_en,
  input  logic [VADDR_W-1:0]   be_redirect_pc,
  input  logic [FSQ_IDX_W-1:0] be_redirect_fsq_idx,
  input  logic                 pd_redirect_en,
  input  logic [VADDR_W-1:0]   pd_redirect_pc,
  input  logic [FSQ_IDX_W-1:0] pd_redirect_fsq_idx,
  input  logic                 ibuf_full,
  input  logic                 fsq_ready,
  output logic                 redirect_valid,
  output logic [VADDR_W-1:0]   redirect_pc,
  output logic [FSQ_IDX_W-1:0] redirect_fsq_idx,
  output logic                 redirect_src,
  output logic                 fe_flush,
  output logic                 fetch_stall,
  output logic [CNT_W-1:0]     be_cnt,
  output logic [CNT_W-1:0]     pd_cnt,
  output logic [CNT_W-1:0]     pd_drop_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       pd_take;
  logic       pd_drop;
  logic       handshake;

  // Predecode redirects only count when nothing older is in flight; otherwise they come from squashed blocks.
  assign pd_take   = pd_redirect_en && (state == IDLE) && !be_redirect_en && !ibuf_full;
  assign pd_drop   = pd_redirect_en && !pd_take;
  assign handshake = redirect_valid && fsq_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      flush_cnt        <= 4'd0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      redirect_fsq_idx <= '0;
      redirect_src     <= 1'b0;
      fe_flush         <= 1'b0;
      fetch_stall      <= 1'b0;
      be_cnt           <= '0;
      pd_cnt           <= '0;
      pd_drop_cnt      <= '0;
    end else begin
      fe_flush <= be_redirect_en || pd_take;

      if (be_redirect_en && be_cnt != '1)   be_cnt      <= be_cnt + 1'b1;
      if (pd_take && pd_cnt != '1)          pd_cnt      <= pd_cnt + 1'b1;
      if (pd_drop && pd_drop_cnt != '1)     pd_drop_cnt <= pd_drop_cnt + 1'b1;

      if (be_redirect_en || pd_take) begin
        redirect_valid   <= 1'b1;
        redirect_pc      <= be_redirect_en ? be_redirect_pc : pd_redirect_pc;
        redirect_fsq_idx <= be_redirect_en ? be_redirect_fsq_idx : pd_redirect_fsq_idx;
        redirect_src     <= !be_redirect_en;
        fetch_stall      <= 1'b1;
        state            <= HOLD;
      end else begin
        case (state)
          HOLD: begin
            if (handshake) begin
              redirect_valid <= 1'b0;
              if (FLUSH_CYCLES == 0) begin
                state       <= IDLE;
                fetch_stall <= 1'b0;
              end else begin
                state     <= FLUSH;
                flush_cnt <= FLUSH_INIT;
              end
            end
          end
          FLUSH: begin
            if (flush_cnt == 4'd0) begin
              state       <= IDLE;
              fetch_stall <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frontend_redirect_arbiter.sv
// Directed bench for frontend_redirect_arbiter; a second instance with no drain window shares the stimulus.
module tb_frontend_redirect_arbiter;

  localparam int VADDR_W   = 39;
  localparam int FSQ_IDX_W = 4;
  localparam int CNT_W     = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 be_redirect_en;
  logic [VADDR_W-1:0]   be_redirect_pc;
  logic [FSQ_IDX_W-1:0] be_redirect_fsq_idx;
  logic                 pd_redirect_en;
  logic [VADDR_W-1:0]   pd_redirect_pc;
  logic [FSQ_IDX_W-1:0] pd_redirect_fsq_idx;
  logic                 ibuf_full;
  logic                 fsq_ready;

  logic                 redirect_valid, redirect_src, fe_flush, fetch_stall;
  logic [VADDR_W-1:0]   redirect_pc;
  logic [FSQ_IDX_W-1:0] redirect_fsq_idx;
  logic [CNT_W-1:0]     be_cnt, pd_cnt, pd_drop_cnt;

  logic                 z_valid, z_src, z_flush, z_stall;
  logic [VADDR_W-1:0]   z_pc;
  logic [FSQ_IDX_W-1:0] z_idx;
  logic [CNT_W-1:0]     z_be_cnt, z_pd_cnt, z_pd_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frontend_redirect_arbiter #(.VADDR_W(VADDR_W), .FSQ_IDX_W(FSQ_IDX_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .be_redirect_en(be_redirect_en), .be_redirect_pc(be_redirect_pc), .be_redirect_fsq_idx(be_redirect_fsq_idx),
    .pd_redirect_en(pd_redirect_en), .pd_redirect_pc(pd_redirect_pc), .pd_redirect_fsq_idx(pd_redirect_fsq_idx),
    .ibuf_full(ibuf_full), .fsq_ready(fsq_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_fsq_idx(redirect_fsq_idx),
    .redirect_src(redirect_src), .fe_flush(fe_flush), .fetch_stall(fetch_stall),
    .be_cnt(be_cnt), .pd_cnt(pd_cnt), .pd_drop_cnt(pd_drop_cnt)
  );

  frontend_redirect_arbiter #(.VADDR_W(VADDR_W), .FSQ_IDX_W(FSQ_IDX_W), .FLUSH_CYCLES(0), .CNT_W(CNT_W)) dut_nf (
    .clk(clk), .rst(rst),
    .be_redirect_en(be_redirect_en), .be_redirect_pc(be_redirect_pc), .be_redirect_fsq_idx(be_redirect_fsq_idx),
    .pd_redirect_en(pd_redirect_en), .pd_redirect_pc(pd_redirect_pc), .pd_redirect_fsq_idx(pd_redirect_fsq_idx),
    .ibuf_full(ibuf_full), .fsq_ready(fsq_ready),
    .redirect_valid(z_valid), .redirect_pc(z_pc), .redirect_fsq_idx(z_idx),
    .redirect_src(z_src), .fe_flush(z_flush), .fetch_stall(z_stall),
    .be_cnt(z_be_cnt), .pd_cnt(z_pd_cnt), .pd_drop_cnt(z_pd_drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    be_redirect_en = 1'b0;
    pd_redirect_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; be_redirect_en = 1'b0; pd_redirect_en = 1'b0;
    be_redirect_pc = '0; be_redirect_fsq_idx = '0; pd_redirect_pc = '0; pd_redirect_fsq_idx = '0;
    ibuf_full = 1'b0; fsq_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_valid", 64'(redirect_valid), 64'd0);
    check("rst_flush", 64'(fe_flush), 64'd0);
    check("rst_stall", 64'(fetch_stall), 64'd0);
    check("rst_pc", 64'(redirect_pc), 64'd0);
    check("rst_cnts", 64'({be_cnt, pd_cnt, pd_drop_cnt}), 64'd0);

    // Predecode capture from idle with immediate handshake.
    pd_redirect_en = 1'b1; pd_redirect_pc = 39'h80000040; pd_redirect_fsq_idx = 4'd3;
    cyc(); idle_inputs();
    check("pd_valid", 64'(redirect_valid), 64'd1);
    check("pd_src", 64'(redirect_src), 64'd1);
    check("pd_pc", 64'(redirect_pc), 64'h80000040);
    check("pd_idx", 64'(redirect_fsq_idx), 64'd3);
    check("pd_flush", 64'(fe_flush), 64'd1);
    check("pd_stall_hold", 64'(fetch_stall), 64'd1);
    check("pd_cnt", 64'(pd_cnt), 64'd1);
    cyc();
    check("pd_fl1_valid", 64'(redirect_valid), 64'd0);
    check("pd_fl1_flush", 64'(fe_flush), 64'd0);
    check("pd_fl1_stall", 64'(fetch_stall), 64'd1);
    cyc();
    check("pd_fl2_stall", 64'(fetch_stall), 64'd1);
    cyc();
    check("pd_idle_stall", 64'(fetch_stall), 64'd0);
    check("pd_idle_valid", 64'(redirect_valid), 64'd0);

    // Simultaneous requests, then FSQ backpressure for 5 cycles.
    fsq_ready = 1'b0;
    be_redirect_en = 1'b1; be_redirect_pc = 39'h100; be_redirect_fsq_idx = 4'd5;
    pd_redirect_en = 1'b1; pd_redirect_pc = 39'h200; pd_redirect_fsq_idx = 4'd6;
    cyc(); idle_inputs();
    check("both_pc", 64'(redirect_pc), 64'h100);
    check("both_src", 64'(redirect_src), 64'd0);
    check("both_be_cnt", 64'(be_cnt), 64'd1);
    check("both_drop_cnt", 64'(pd_drop_cnt), 64'd1);
    check("both_pd_cnt", 64'(pd_cnt), 64'd1);
    check("both_flush", 64'(fe_flush), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_valid", 64'(redirect_valid), 64'd1);
      check("bp_pc", 64'(redirect_pc), 64'h100);
      check("bp_idx", 64'(redirect_fsq_idx), 64'd5);
      check("bp_flush", 64'(fe_flush), 64'd0);
    end
    fsq_ready = 1'b1;
    cyc();
    check("bp_rel_valid", 64'(redirect_valid), 64'd0);
    check("bp_rel_stall", 64'(fetch_stall), 64'd1);

    // Backend request in FLUSH with the drain counter at 1.
    be_redirect_en = 1'b1; be_redirect_pc = 39'h300; be_redirect_fsq_idx = 4'd7;
    cyc();
    check("fl_be_valid", 64'(redirect_valid), 64'd1);
    check("fl_be_pc", 64'(redirect_pc), 64'h300);
    check("fl_be_flush", 64'(fe_flush), 64'd1);
    check("fl_be_stall", 64'(fetch_stall), 64'd1);
    // Backend request coinciding with the handshake in HOLD.
    be_redirect_pc = 39'h400; be_redirect_fsq_idx = 4'd8;
    cyc(); idle_inputs();
    check("hs_be_valid", 64'(redirect_valid), 64'd1);
    check("hs_be_pc", 64'(redirect_pc), 64'h400);
    check("hs_be_idx", 64'(redirect_fsq_idx), 64'd8);
    check("hs_be_flush", 64'(fe_flush), 64'd1);
    check("hs_be_cnt", 64'(be_cnt), 64'd3);
    cyc();
    check("hs_fl1_valid", 64'(redirect_valid), 64'd0);
    check("hs_fl1_stall", 64'(fetch_stall), 64'd1);
    check("hs_fl1_flush", 64'(fe_flush), 64'd0);
    cyc();
    check("hs_fl2_stall", 64'(fetch_stall), 64'd1);
    cyc();
    check("hs_idle_stall", 64'(fetch_stall), 64'd0);

    // Predecode with a full instruction buffer is dropped.
    ibuf_full = 1'b1; pd_redirect_en = 1'b1; pd_redirect_pc = 39'h600;
    cyc(); idle_inputs(); ibuf_full = 1'b0;
    check("ibuf_valid", 64'(redirect_valid), 64'd0);
    check("ibuf_stall", 64'(fetch_stall), 64'd0);
    check("ibuf_drop", 64'(pd_drop_cnt), 64'd2);
    check("ibuf_pd_cnt", 64'(pd_cnt), 64'd1);
    check("nf_ibuf_drop", 64'(z_pd_drop_cnt), 64'd2);

    // Zero drain window: IDLE straight after the handshake.
    pd_redirect_en = 1'b1; pd_redirect_pc = 39'h700; pd_redirect_fsq_idx = 4'd9;
    cyc(); idle_inputs();
    check("nf_valid", 64'(z_valid), 64'd1);
    check("nf_pc", 64'(z_pc), 64'h700);
    check("nf_stall_hold", 64'(z_stall), 64'd1);
    cyc();
    check("nf_after_valid", 64'(z_valid), 64'd0);
    check("nf_after_stall", 64'(z_stall), 64'd0);
    check("nf_ref_stall", 64'(fetch_stall), 64'd1);
    cyc(); cyc();
    check("ref_idle_stall", 64'(fetch_stall), 64'd0);

    // Reset while in HOLD abandons the redirect.
    fsq_ready = 1'b0;
    be_redirect_en = 1'b1; be_redirect_pc = 39'h500; be_redirect_fsq_idx = 4'd2;
    cyc(); idle_inputs();
    check("prerst_valid", 64'(redirect_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; fsq_ready = 1'b1;
    check("hrst_valid", 64'(redirect_valid), 64'd0);
    check("hrst_stall", 64'(fetch_stall), 64'd0);
    check("hrst_flush", 64'(fe_flush), 64'd0);
    check("hrst_pc", 64'(redirect_pc), 64'd0);
    check("hrst_src_idx", 64'({redirect_src, redirect_fsq_idx}), 64'd0);
    check("hrst_be_cnt", 64'(be_cnt), 64'd0);
    cyc();
    check("hrst_post_flush", 64'(fe_flush), 64'd0);
    check("hrst_post_stall", 64'(fetch_stall), 64'd0);

    // Drop counter saturation.
    ibuf_full = 1'b1; pd_redirect_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      cyc();
      if (i == 65533) check("sat_pre", 64'(pd_drop_cnt), 64'hFFFE);
    end
    idle_inputs(); ibuf_full = 1'b0;
    check("sat_drop", 64'(pd_drop_cnt), 64'hFFFF);
    check("sat_pd_cnt", 64'(pd_cnt), 64'd0);
    check("sat_valid", 64'(redirect_valid), 64'd0);
    cyc();
    check("sat_hold", 64'(pd_drop_cnt), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
